sa_drain_collector: RTL and testbench

Result-side consumer for the `pe_array_8x8` drain interface. On each tile-complete pulse it issues a single `c_drain_req`. It then captures the SIDE*SIDE row-major accumulator words the array emits on `c_valid`/`c_data`/`c_last` into an internal buffer. It re-emits those words on a backpressured valid/ready output stream toward the writeback path. The array drain has no flow control, so this block absorbs it and is the only place result backpressure is handled.

---
 rtl/sa_pkg.sv | 14 +
 rtl/sa_sync_fifo.sv | 61 ++++++
 rtl/sa_drain_collector.sv | 129 ++++++++++++
 tb/tb_sa_drain_collector.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared constants and drain FSM state encoding for the systolic-array result path.
package sa_pkg;

    localparam int SA_SIDE     = 8;
    localparam int SA_ACC_BITS = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SPACE,
        REQ,
        CAPTURE
    } drain_state_e;

endpackage

// File: rtl/sa_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head visible one cycle after the write edge.
// Pushes into a full FIFO and pops from an empty one are ignored.
module sa_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdat,
    input  logic             pop,
    output logic [WIDTH-1:0] rdat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdat    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: contents are only observable through the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdat;
    end

endmodule

// File: rtl/sa_drain_collector.sv
// Requests one array drain per tile, buffers the unflowcontrolled words, replays them on valid/ready.
// Capture-to-output latency 1 cycle; m_tready stalls only the output side, the FIFO absorbs the drain.
module sa_drain_collector
    import sa_pkg::*;
#(
    parameter int SIDE     = SA_SIDE,
    parameter int ACC_BITS = SA_ACC_BITS
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                tile_done,
    output logic                c_drain_req,
    input  logic                c_busy,
    input  logic                c_valid,
    input  logic [ACC_BITS-1:0] c_data,
    input  logic                c_last,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic [ACC_BITS-1:0] m_tdata,
    output logic                m_tlast,
    output logic                busy,
    output logic                err_proto,
    input  logic                clear_err
);

    localparam int              TILE     = SIDE * SIDE;
    localparam int              CW       = $clog2(TILE) + 1;
    localparam logic [CW-1:0]   LAST_IDX = CW'(TILE - 1);

    drain_state_e      state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              err_q, err_d;
    logic              new_err, word_last, at_end;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ACC_BITS:0] fifo_wdat, fifo_rdat;
    logic              pop_last;
    logic              unused_ok;

    assign fifo_pop  = m_tvalid && m_tready;
    // Only one tile is ever buffered, so popping a last-flagged word empties the FIFO.
    assign pop_last  = fifo_pop && fifo_rdat[ACC_BITS];
    assign at_end    = (cnt_q == LAST_IDX);
    assign unused_ok = c_busy ^ fifo_full;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        new_err     = 1'b0;
        word_last   = 1'b0;
        fifo_push   = 1'b0;
        fifo_wdat   = {c_last, c_data};
        c_drain_req = 1'b0;

        if (tile_done && state_q != IDLE) begin
            if (pend_q) new_err = 1'b1;
            else        pend_d  = 1'b1;
        end
        if (c_valid && state_q != CAPTURE) new_err = 1'b1;

        case (state_q)
            IDLE: begin
                if (tile_done || pend_q) begin
                    pend_d  = 1'b0;
                    if (tile_done && pend_q) new_err = 1'b1;
                    state_d = fifo_empty ? REQ : WAIT_SPACE;
                end
            end
            WAIT_SPACE: begin
                if (fifo_empty || pop_last) state_d = REQ;
            end
            REQ: begin
                c_drain_req = 1'b1;
                cnt_d       = '0;
                state_d     = CAPTURE;
            end
            CAPTURE: begin
                if (c_valid) begin
                    word_last = c_last || at_end;
                    fifo_push = 1'b1;
                    fifo_wdat = {word_last, c_data};
                    cnt_d     = cnt_q + CW'(1);
                    if (c_last != at_end) new_err = 1'b1;
                    if (word_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        err_d = new_err ? 1'b1 : (clear_err ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    sa_sync_fifo #(
        .WIDTH (ACC_BITS + 1),
        .DEPTH (TILE)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fifo_push),
        .wdat  (fifo_wdat),
        .pop   (fifo_pop),
        .rdat  (fifo_rdat),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m_tvalid  = !fifo_empty;
    assign m_tdata   = fifo_empty ? '0 : fifo_rdat[ACC_BITS-1:0];
    assign m_tlast   = !fifo_empty && fifo_rdat[ACC_BITS];
    assign busy      = (state_q != IDLE) || !fifo_empty || pend_q;
    assign err_proto = err_q;

endmodule

// File: tb/tb_sa_drain_collector.sv
// Randomized bench for sa_drain_collector with a queue-based reference of the expected output stream.
module tb_sa_drain_collector;

    localparam int TILE = 64;

    logic        clk = 1'b0;
    logic        rstn, tile_done, c_busy, c_valid, c_last, m_tready, clear_err;
    logic [31:0] c_data;
    logic        c_drain_req, m_tvalid, m_tlast, busy, err_proto;
    logic [31:0] m_tdata;

    sa_drain_collector dut (
        .clk         (clk),
        .rstn        (rstn),
        .tile_done   (tile_done),
        .c_drain_req (c_drain_req),
        .c_busy      (c_busy),
        .c_valid     (c_valid),
        .c_data      (c_data),
        .c_last      (c_last),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tdata     (m_tdata),
        .m_tlast     (m_tlast),
        .busy        (busy),
        .err_proto   (err_proto),
        .clear_err   (clear_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        last;
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0, n_err = 0;
    int   req_cnt = 0, req_cyc = -1, tlast_hs_cyc = -1, pops = 0;
    bit   lat_mode = 1'b0;
    int   rdy_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: every accepted word must match the head of the reference queue.
    always @(negedge clk) begin
        if (rstn) begin
            if (c_drain_req) begin
                req_cnt++;
                req_cyc = cyc;
            end
            if (m_tvalid && m_tready) begin
                pops++;
                if (exp_q.size() == 0) chk("extra_word", 1, 0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("m_tdata", m_tdata, e.dat);
                    chk("m_tlast", m_tlast, e.last);
                    if (lat_mode) chk("latency", cyc, e.cyc + 1);
                end
                if (m_tlast) tlast_hs_cyc = cyc;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = (rdy_mode == 0) ? 1'b1 :
                       (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tile(output int c);
        tile_done = 1'b1;
        c = cyc;
        step();
        tile_done = 1'b0;
    endtask

    // Array model: waits for the drain request, then emits n words, c_last at index last_at.
    task automatic drain(input int n, input int last_at, input bit seq, input bit gaps,
                         output int seen);
        int t = 0;
        seen = -1;
        while (!c_drain_req && t < 300) begin
            step();
            t++;
        end
        if (!c_drain_req) begin
            chk("req_timeout", 0, 1);
            return;
        end
        seen = cyc;
        for (int i = 0; i < n; i++) begin
            step();
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    c_valid = 1'b0;
                    step();
                end
            end
            c_valid = 1'b1;
            c_data  = seq ? 32'(i) : $urandom;
            c_last  = (i == last_at);
            exp_q.push_back('{last: (i == last_at) || (i == TILE - 1), dat: c_data, cyc: cyc});
        end
        step();
        c_valid = 1'b0;
        c_last  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 3000) begin
            step();
            t++;
        end
        chk(tag, (t < 3000), 1);
    endtask

    initial begin
        int td, seen, seen2, p0;
        rstn = 1'b0; tile_done = 1'b0; c_busy = 1'b0; c_valid = 1'b0;
        c_last = 1'b0; c_data = '0; m_tready = 1'b1; clear_err = 1'b0;

        // Reset
        repeat (5) @(posedge clk);
        #1;
        chk("rst_c_drain_req", c_drain_req, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_proto", err_proto, 0);
        rstn = 1'b1;
        step();
        chk("post_rst_busy", busy, 0);

        // Nominal tile, full throughput
        rdy_mode = 0; lat_mode = 1'b1; req_cnt = 0;
        step();
        pulse_tile(td);
        drain(TILE, TILE - 1, 1'b1, 1'b0, seen);
        chk("nom_req_delay", seen, td + 1);
        wait_idle("nom_drain_timeout");
        chk("nom_req_pulses", req_cnt, 1);
        chk("nom_err", err_proto, 0);
        lat_mode = 1'b0;

        // Output stalled for the whole capture
        rdy_mode = 1; p0 = pops;
        step();
        pulse_tile(td);
        drain(TILE, TILE - 1, 1'b0, 1'b1, seen);
        chk("stall_valid", m_tvalid, 1);
        chk("stall_head", m_tdata, exp_q[0].dat);
        rdy_mode = 0;
        wait_idle("stall_drain_timeout");
        chk("stall_pops", pops - p0, TILE);
        chk("stall_err", err_proto, 0);

        // Overlapped tiles under random backpressure
        rdy_mode = 2;
        step();
        pulse_tile(td);
        drain(TILE, TILE - 1, 1'b0, 1'b1, seen);
        chk("ovl_backlog", m_tvalid, 1);
        pulse_tile(td);
        drain(TILE, TILE - 1, 1'b0, 1'b0, seen2);
        chk("ovl_req_after_tlast", seen2, tlast_hs_cyc + 1);
        wait_idle("ovl_drain_timeout");
        chk("ovl_err", err_proto, 0);

        // Short tile: c_last on word 10
        rdy_mode = 0;
        step();
        pulse_tile(td);
        drain(11, 10, 1'b1, 1'b0, seen);
        wait_idle("short_drain_timeout");
        chk("short_err", err_proto, 1);
        chk("short_idle", busy, 0);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("clear_err", err_proto, 0);

        // Stray word in IDLE, then error-vs-clear priority
        c_valid = 1'b1; c_data = $urandom;
        step();
        c_valid = 1'b0;
        chk("stray_err", err_proto, 1);
        chk("stray_no_valid", m_tvalid, 0);
        c_valid = 1'b1; clear_err = 1'b1;
        step();
        c_valid = 1'b0; clear_err = 1'b0;
        chk("err_beats_clear", err_proto, 1);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("clear_err2", err_proto, 0);

        // Reset in the middle of a capture
        rdy_mode = 1;
        step();
        pulse_tile(td);
        drain(20, -1, 1'b0, 1'b0, seen);
        chk("pre_rst_valid", m_tvalid, 1);
        #1 rstn = 1'b0;
        #1;
        chk("midrst_m_tvalid", m_tvalid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_m_tdata", m_tdata, 0);
        exp_q.delete();
        step();
        step();
        rstn = 1'b1; rdy_mode = 0;
        step();
        c_valid = 1'b1; c_data = $urandom;
        step();
        c_valid = 1'b0;
        chk("inflight_err", err_proto, 1);
        chk("inflight_no_valid", m_tvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
